// File: rtl/exe_stage.sv
// Execute stage: registers ID operands for the ALU, stretches multiplies over MUL_LAT stall cycles,
// and hands the ALU result to MEM. Define EXE_FWD_EN to enable the EX->ID bypass outputs.
module exe_stage #(
    parameter int unsigned MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        es_flush,
    input  logic        ds_to_es_valid,
    output logic        es_allowin,
    input  logic [11:0] ds_alu_op,
    input  logic [31:0] ds_alu_src1,
    input  logic [31:0] ds_alu_src2,
    input  logic [4:0]  ds_dest,
    input  logic        ds_gr_we,
    input  logic [31:0] ds_pc,
    output logic [11:0] alu_op,
    output logic [31:0] alu_src1,
    output logic [31:0] alu_src2,
    input  logic [31:0] alu_result,
    output logic        es_to_ms_valid,
    input  logic        ms_allowin,
    output logic [31:0] es_result,
    output logic [4:0]  es_dest,
    output logic        es_gr_we,
    output logic [31:0] es_pc,
    output logic        es_fwd_valid,
    output logic [4:0]  es_fwd_dest,
    output logic        es_fwd_ready,
    output logic [31:0] es_fwd_data
);

    localparam logic [3:0] MulLat = MUL_LAT[3:0];

    logic        es_valid_q, es_valid_d;
    logic [3:0]  mul_cnt_q, mul_cnt_d;
    logic [11:0] op_q;
    logic [31:0] src1_q, src2_q, pc_q;
    logic [4:0]  dest_q;
    logic        gr_we_q;
    logic        es_ready_go;
    logic        load;

    assign es_ready_go    = (mul_cnt_q == 4'd0);
    assign es_allowin     = ~es_valid_q | (es_ready_go & ms_allowin);
    assign es_to_ms_valid = es_valid_q & es_ready_go;
    assign load           = ds_to_es_valid & es_allowin & ~es_flush;

    always_comb begin
        es_valid_d = es_valid_q;
        mul_cnt_d  = mul_cnt_q;
        if (es_flush) begin
            es_valid_d = 1'b0;
            mul_cnt_d  = '0;
        end else if (es_allowin) begin
            es_valid_d = ds_to_es_valid;
            if (load) begin
                mul_cnt_d = ds_alu_op[7] ? MulLat : 4'd0;
            end
        end else if (es_valid_q && mul_cnt_q != 4'd0) begin
            mul_cnt_d = mul_cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            es_valid_q <= 1'b0;
            mul_cnt_q  <= '0;
        end else begin
            es_valid_q <= es_valid_d;
            mul_cnt_q  <= mul_cnt_d;
        end
    end

    // Payload only moves on an accepted instruction; bubbles and flushes leave it untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q    <= '0;
            src1_q  <= '0;
            src2_q  <= '0;
            dest_q  <= '0;
            gr_we_q <= 1'b0;
            pc_q    <= '0;
        end else if (load) begin
            op_q    <= ds_alu_op;
            src1_q  <= ds_alu_src1;
            src2_q  <= ds_alu_src2;
            dest_q  <= ds_dest;
            gr_we_q <= ds_gr_we;
            pc_q    <= ds_pc;
        end
    end

    assign alu_op    = op_q;
    assign alu_src1  = src1_q;
    assign alu_src2  = src2_q;
    assign es_result = alu_result;
    assign es_dest   = dest_q;
    assign es_gr_we  = es_valid_q & gr_we_q;
    assign es_pc     = pc_q;

`ifdef EXE_FWD_EN
    assign es_fwd_valid = es_valid_q & gr_we_q & (dest_q != 5'd0);
    assign es_fwd_dest  = dest_q;
    assign es_fwd_data  = alu_result;
    assign es_fwd_ready = es_ready_go;
`else
    assign es_fwd_valid = 1'b0;
    assign es_fwd_dest  = '0;
    assign es_fwd_data  = '0;
    assign es_fwd_ready = 1'b0;
`endif

endmodule

// File: tb/tb_exe_stage.sv
// Scoreboard bench for exe_stage: directed scenarios plus randomized traffic against a
// transaction-level occupancy model; a negedge monitor checks every presented output.
module tb_exe_stage;

    localparam int unsigned LAT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        es_flush = 1'b0;
    logic        ds_to_es_valid = 1'b0;
    logic        es_allowin;
    logic [11:0] ds_alu_op = '0;
    logic [31:0] ds_alu_src1 = '0;
    logic [31:0] ds_alu_src2 = '0;
    logic [4:0]  ds_dest = '0;
    logic        ds_gr_we = 1'b0;
    logic [31:0] ds_pc = '0;
    logic [11:0] alu_op;
    logic [31:0] alu_src1, alu_src2, alu_result;
    logic        es_to_ms_valid;
    logic        ms_allowin = 1'b1;
    logic [31:0] es_result;
    logic [4:0]  es_dest;
    logic        es_gr_we;
    logic [31:0] es_pc;
    logic        es_fwd_valid;
    logic [4:0]  es_fwd_dest;
    logic        es_fwd_ready;
    logic [31:0] es_fwd_data;

    exe_stage #(.MUL_LAT(LAT)) dut (
        .clk(clk), .reset(reset), .es_flush(es_flush), .ds_to_es_valid(ds_to_es_valid),
        .es_allowin(es_allowin), .ds_alu_op(ds_alu_op), .ds_alu_src1(ds_alu_src1),
        .ds_alu_src2(ds_alu_src2), .ds_dest(ds_dest), .ds_gr_we(ds_gr_we), .ds_pc(ds_pc),
        .alu_op(alu_op), .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_result(alu_result),
        .es_to_ms_valid(es_to_ms_valid), .ms_allowin(ms_allowin), .es_result(es_result),
        .es_dest(es_dest), .es_gr_we(es_gr_we), .es_pc(es_pc), .es_fwd_valid(es_fwd_valid),
        .es_fwd_dest(es_fwd_dest), .es_fwd_ready(es_fwd_ready), .es_fwd_data(es_fwd_data)
    );

    always #5 clk = ~clk;

    // Op bits: 0 add 1 sub 2 slt 3 sltu 4 and 5 nor 6 or 7 mul 8 xor 9 sll 10 srl 11 lui
    function automatic logic [31:0] ref_alu(input logic [11:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 12; i++) begin
            if (op[i]) begin
                case (i)
                    0:  r = a + b;
                    1:  r = a - b;
                    2:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    3:  r = (a < b) ? 32'd1 : 32'd0;
                    4:  r = a & b;
                    5:  r = ~(a | b);
                    6:  r = a | b;
                    7:  r = a * b;
                    8:  r = a ^ b;
                    9:  r = a << b[4:0];
                    10: r = a >> b[4:0];
                    default: r = b;
                endcase
            end
        end
        return r;
    endfunction

    always_comb alu_result = ref_alu(alu_op, alu_src1, alu_src2);

    typedef struct {
        logic [31:0] res;
        logic [4:0]  dest;
        logic        we;
        logic [31:0] pc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        m_entry;
    logic [31:0] ds_exp = '0;
    bit          m_valid = 0;
    int unsigned m_left = 0;
    bit          m_accepted = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: one slot holding the in-flight instruction and its remaining stall cycles.
    always @(posedge clk or posedge reset) begin
        bit allow, leaving;
        if (reset) begin
            m_valid = 0; m_left = 0; m_accepted = 0;
            exp_q.delete();
        end else begin
            leaving = m_valid && m_left == 0 && ms_allowin;
            allow = !m_valid || leaving;
            m_accepted = 0;
            if (es_flush) begin
                if (m_valid && !leaving && exp_q.size() > 0) void'(exp_q.pop_back());
                m_valid = 0; m_left = 0;
            end else if (allow) begin
                if (ds_to_es_valid) begin
                    m_entry = '{res: ds_exp, dest: ds_dest, we: ds_gr_we, pc: ds_pc};
                    exp_q.push_back(m_entry);
                    m_valid = 1;
                    m_left = ds_alu_op[7] ? LAT : 0;
                    m_accepted = 1;
                end else begin
                    m_valid = 0;
                end
            end else if (m_valid && m_left != 0) begin
                m_left--;
            end
        end
    end

    // Monitor: outputs sampled mid-cycle, after inputs have settled.
    always @(negedge clk) begin
        if (!reset) begin
            check("allowin", {31'd0, es_allowin}, {31'd0, !m_valid || (m_left == 0 && ms_allowin)});
            check("to_ms_valid", {31'd0, es_to_ms_valid}, {31'd0, m_valid && m_left == 0});
            check("gr_we", {31'd0, es_gr_we}, {31'd0, m_valid && m_entry.we});
            if (es_to_ms_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL spurious_output: got result %h, expected no instruction", es_result);
                end else begin
                    check("result", es_result, exp_q[0].res);
                    check("dest", {27'd0, es_dest}, {27'd0, exp_q[0].dest});
                    check("pc", es_pc, exp_q[0].pc);
                    if (ms_allowin) void'(exp_q.pop_front());
                end
            end
`ifdef EXE_FWD_EN
            check("fwd_valid", {31'd0, es_fwd_valid}, {31'd0, m_valid && m_entry.we && m_entry.dest != 0});
            check("fwd_ready", {31'd0, es_fwd_ready}, {31'd0, m_left == 0});
            if (m_valid && m_entry.we && m_entry.dest != 0) begin
                check("fwd_dest", {27'd0, es_fwd_dest}, {27'd0, m_entry.dest});
                if (m_left == 0) check("fwd_data", es_fwd_data, m_entry.res);
            end
`else
            check("fwd_off", {es_fwd_valid, es_fwd_ready, es_fwd_dest, 25'd0} | es_fwd_data, 32'd0);
`endif
        end
    end

    task automatic set_ds(input int idx, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] d, input logic we, input logic [31:0] pc, input logic [31:0] e);
        ds_alu_op = 12'd1 << idx;
        ds_alu_src1 = a; ds_alu_src2 = b;
        ds_dest = d; ds_gr_we = we; ds_pc = pc; ds_exp = e;
        ds_to_es_valid = 1'b1;
    endtask

    task automatic wait_accept();
        int n;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!m_accepted && n < 50);
        if (!m_accepted) begin
            n_checks++;
            $display("FAIL accept_timeout: got no acceptance, expected within 50 cycles");
        end
        ds_to_es_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic reset_checks();
        check("rst_allowin", {31'd0, es_allowin}, 32'd1);
        check("rst_to_ms", {31'd0, es_to_ms_valid}, 32'd0);
        check("rst_result", es_result, 32'd0);
        check("rst_gr_we", {31'd0, es_gr_we}, 32'd0);
        check("rst_fwd", {es_fwd_valid, es_fwd_ready, es_fwd_dest, 25'd0} | es_fwd_data, 32'd0);
    endtask

    initial begin
        #2 reset_checks();
        @(posedge clk); #1 reset = 1'b0;

        // Back-to-back add then sub
        set_ds(0, 32'h7FFF_FFFF, 32'd1, 5'd1, 1'b1, 32'h1000, 32'h8000_0000);
        wait_accept();
        set_ds(1, 32'd5, 32'd7, 5'd2, 1'b1, 32'h1004, 32'hFFFF_FFFE);
        wait_accept();
        idle(2);

        // Multiply stall
        set_ds(7, 32'hFFFF_FFFE, 32'd3, 5'd3, 1'b1, 32'h1008, 32'hFFFF_FFFA);
        wait_accept();
        idle(LAT + 2);

        // Backpressure on slt
        set_ds(2, 32'hFFFF_FFFF, 32'd1, 5'd4, 1'b1, 32'h100C, 32'd1);
        ms_allowin = 1'b0;
        wait_accept();
        idle(3);
        ms_allowin = 1'b1;
        idle(2);

        // Flush on the second stall cycle of a mul with ID presenting a new instruction
        set_ds(7, 32'd6, 32'd7, 5'd5, 1'b1, 32'h1010, 32'd42);
        wait_accept();
        set_ds(0, 32'd10, 32'd20, 5'd6, 1'b1, 32'h1014, 32'd30);
        idle(1);
        es_flush = 1'b1;
        idle(1);
        es_flush = 1'b0;
        wait_accept();
        idle(2);

        // Forwarding cases: or to r5, or to r0, mul to r6
        set_ds(6, 32'h0F0F_0000, 32'h0000_00F0, 5'd5, 1'b1, 32'h1018, 32'h0F0F_00F0);
        wait_accept();
        set_ds(6, 32'h0F0F_0000, 32'h0000_00F0, 5'd0, 1'b1, 32'h101C, 32'h0F0F_00F0);
        wait_accept();
        set_ds(7, 32'd9, 32'd9, 5'd6, 1'b1, 32'h1020, 32'd81);
        wait_accept();
        idle(LAT + 2);

        // Asynchronous reset in the middle of a mul stall
        set_ds(7, 32'd3, 32'd4, 5'd7, 1'b1, 32'h1024, 32'd12);
        wait_accept();
        #3 reset = 1'b1;
        #1 reset_checks();
        idle(2);
        reset = 1'b0;

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            int idx;
            logic [31:0] a, b;
            idx = ($urandom_range(0, 9) < 3) ? 7 : int'($urandom_range(0, 11));
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            set_ds(idx, a, b, 5'($urandom), 1'($urandom), $urandom, ref_alu(12'd1 << idx, a, b));
            ds_to_es_valid = ($urandom_range(0, 3) != 0);
            ms_allowin = ($urandom_range(0, 3) != 0);
            es_flush = ($urandom_range(0, 15) == 0);
            @(posedge clk); #1;
        end
        ds_to_es_valid = 1'b0;
        es_flush = 1'b0;
        ms_allowin = 1'b1;
        idle(LAT + 3);
        check("drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected end before 200000");
        $fatal(1, "timeout");
    end

endmodule
